// File: rtl/cell_bist.sv
// Built-in self-test sequencer for the XOR/XNOR/MAJ cell set: sweeps all eight
// {c,b,a} vectors, compares cell outputs to golden functions, records failures.
module cell_bist #(
   parameter int SETTLE       = 2,
   parameter int LOOPS        = 1,
   parameter int STOP_ON_FAIL = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   input  logic [7:0] dut_o,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] fail_mask,
   output logic [2:0] fail_vec,
   output logic [7:0] fail_loop
);

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
   localparam logic [7:0] LAST_LOOP = 8'(LOOPS - 1);

   typedef enum logic [1:0] {IDLE, HOLD, CHECK, DONE} state_t;

   state_t     state;
   logic [2:0] vec;
   logic [7:0] loop_cnt;
   logic [3:0] settle_cnt;

   logic       x2, x3, maj;
   logic [7:0] golden;
   logic [7:0] mismatch;
   logic [7:0] mask_next;
   logic       stop_now;

   assign a = vec[0];
   assign b = vec[1];
   assign c = vec[2];

   always_comb begin
      x2        = vec[0] ^ vec[1];
      x3        = x2 ^ vec[2];
      maj       = (vec[0] & vec[1]) | (vec[1] & vec[2]) | (vec[0] & vec[2]);
      golden    = {maj, x3, x3, x3, ~x2, ~x2, x2, x2};
      mismatch  = dut_o ^ golden;
      mask_next = fail_mask | mismatch;
      stop_now  = ((mismatch != '0) && (STOP_ON_FAIL != 0)) ||
                  ((vec == 3'd7) && (loop_cnt == LAST_LOOP));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         vec        <= '0;
         loop_cnt   <= '0;
         settle_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_mask  <= '0;
         fail_vec   <= '0;
         fail_loop  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= HOLD;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  fail_mask  <= '0;
                  fail_vec   <= '0;
                  fail_loop  <= '0;
                  loop_cnt   <= '0;
                  vec        <= '0;
                  settle_cnt <= SETTLE_LD;
               end
            end
            HOLD: begin
               settle_cnt <= settle_cnt - 4'd1;
               if (settle_cnt == 4'd1) state <= CHECK;
            end
            CHECK: begin
               fail_mask <= mask_next;
               // An empty mask means no earlier failure in this test.
               if ((mismatch != '0) && (fail_mask == '0)) begin
                  fail_vec  <= vec;
                  fail_loop <= loop_cnt;
               end
               if (stop_now) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  vec   <= '0;
                  pass  <= (mask_next == '0);
               end else begin
                  vec        <= vec + 3'd1;
                  if (vec == 3'd7) loop_cnt <= loop_cnt + 8'd1;
                  settle_cnt <= SETTLE_LD;
                  state      <= HOLD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cell_bist.sv
// Scoreboard bench for cell_bist: stimulus pushes expected completion records,
// a monitor pops and compares them on each rising done.
module tb_cell_bist;

   typedef struct {
      logic       p;
      logic [7:0] m;
      logic [2:0] v;
      logic [7:0] l;
      int         cy;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
   logic       a0, b0, c0, a1, b1, c1, a2, b2, c2;
   logic [7:0] o0, o1, o2;
   logic       busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
   logic [7:0] fm0, fm1, fm2, fl0, fl1, fl2;
   logic [2:0] fv0, fv1, fv2;
   logic       f0 = 1'b0;

   exp_t q0[$], q1[$], q2[$];

   function automatic logic [7:0] cells(input logic a, input logic b, input logic c);
      logic x2, x3, mj;
      x2 = a ^ b;
      x3 = a ^ b ^ c;
      mj = (a & b) | (b & c) | (a & c);
      return {mj, x3, x3, x3, ~x2, ~x2, x2, x2};
   endfunction

   // Cell models: u0 optionally has maj3 stuck-at-0, u1 has xor3_8t_a inverted.
   assign o0 = cells(a0, b0, c0) & (f0 ? 8'h7F : 8'hFF);
   assign o1 = cells(a1, b1, c1) ^ 8'h10;
   assign o2 = cells(a2, b2, c2);

   cell_bist u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .c(c0), .dut_o(o0),
      .busy(busy0), .done(done0), .pass(pass0), .fail_mask(fm0), .fail_vec(fv0), .fail_loop(fl0));

   cell_bist #(.SETTLE(2), .LOOPS(2), .STOP_ON_FAIL(0)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c(c1), .dut_o(o1),
      .busy(busy1), .done(done1), .pass(pass1), .fail_mask(fm1), .fail_vec(fv1), .fail_loop(fl1));

   cell_bist #(.SETTLE(1), .LOOPS(1), .STOP_ON_FAIL(1)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .c(c2), .dut_o(o2),
      .busy(busy2), .done(done2), .pass(pass2), .fail_mask(fm2), .fail_vec(fv2), .fail_loop(fl2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic cmp_rec(input string who, input exp_t e, input logic p, input logic [7:0] m,
                          input logic [2:0] v, input logic [7:0] l);
      chk({who, " done_cycle"}, cyc, e.cy);
      chk({who, " pass"}, {31'd0, p}, {31'd0, e.p});
      chk({who, " fail_mask"}, {24'd0, m}, {24'd0, e.m});
      chk({who, " fail_vec"}, {29'd0, v}, {29'd0, e.v});
      chk({who, " fail_loop"}, {24'd0, l}, {24'd0, e.l});
   endtask

   // Monitor: every rising done must match the oldest pending expectation.
   logic pd0 = 1'b0, pd1 = 1'b0, pd2 = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (done0 && !pd0) begin
         if (q0.size() == 0) chk("u0 unexpected_done", 1, 0);
         else begin e = q0.pop_front(); cmp_rec("u0", e, pass0, fm0, fv0, fl0); end
      end
      if (done1 && !pd1) begin
         if (q1.size() == 0) chk("u1 unexpected_done", 1, 0);
         else begin e = q1.pop_front(); cmp_rec("u1", e, pass1, fm1, fv1, fl1); end
      end
      if (done2 && !pd2) begin
         if (q2.size() == 0) chk("u2 unexpected_done", 1, 0);
         else begin e = q2.pop_front(); cmp_rec("u2", e, pass2, fm2, fv2, fl2); end
      end
      pd0 = done0;
      pd1 = done1;
      pd2 = done2;
   end

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   function automatic exp_t mk(input logic p, input logic [7:0] m, input logic [2:0] v,
                               input logic [7:0] l, input int cy);
      exp_t e;
      e.p = p; e.m = m; e.v = v; e.l = l; e.cy = cy;
      return e;
   endfunction

   task automatic chk_reset_u0(input string tag);
      chk({tag, " abc"}, {29'd0, c0, b0, a0}, 0);
      chk({tag, " busy"}, {31'd0, busy0}, 0);
      chk({tag, " done"}, {31'd0, done0}, 0);
      chk({tag, " pass"}, {31'd0, pass0}, 0);
      chk({tag, " fail_mask"}, {24'd0, fm0}, 0);
      chk({tag, " fail_vec"}, {29'd0, fv0}, 0);
      chk({tag, " fail_loop"}, {24'd0, fl0}, 0);
   endtask

   initial begin
      int e;
      int t;
      repeat (3) @(negedge clk);
      chk_reset_u0("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Ideal cells, defaults: each vector held 3 cycles, done at E+24.
      start0 = 1'b1;
      @(negedge clk);
      e = cyc;
      start0 = 1'b0;
      chk("ideal busy_at_E", {31'd0, busy0}, 1);
      q0.push_back(mk(1'b1, 8'h00, 3'd0, 8'd0, e + 24));
      for (t = 0; t < 24; t++) begin
         if (t > 0) @(negedge clk);
         chk("ideal abc", {29'd0, c0, b0, a0}, t / 3);
      end
      wait_until(e + 26);
      chk("ideal done_held", {31'd0, done0}, 1);
      chk("ideal abc_after", {29'd0, c0, b0, a0}, 0);

      // maj3 stuck-at-0 with stop-on-fail: first mismatch at vec 3, done at E+12.
      f0 = 1'b1;
      start0 = 1'b1;
      @(negedge clk);
      e = cyc;
      start0 = 1'b0;
      q0.push_back(mk(1'b0, 8'h80, 3'd3, 8'd0, e + 12));
      wait_until(e + 14);
      f0 = 1'b0;

      // xor3_8t_a inverted, accumulate over two sweeps: done at E+48.
      start1 = 1'b1;
      @(negedge clk);
      e = cyc;
      start1 = 1'b0;
      q1.push_back(mk(1'b0, 8'h10, 3'd0, 8'd0, e + 48));
      wait_until(e + 50);
      chk("u1 busy_low", {31'd0, busy1}, 0);

      // Reset mid-test at E+10, then a clean rerun.
      start0 = 1'b1;
      @(negedge clk);
      e = cyc;
      start0 = 1'b0;
      wait_until(e + 10);
      chk("prereset busy", {31'd0, busy0}, 1);
      rst_n = 1'b0;
      #1;
      chk_reset_u0("midreset");
      chk("midreset u1 done", {31'd0, done1}, 0);
      chk("midreset u1 fail_mask", {24'd0, fm1}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      e = cyc;
      start0 = 1'b0;
      q0.push_back(mk(1'b1, 8'h00, 3'd0, 8'd0, e + 24));
      wait_until(e + 26);

      // start held high: faulty run, then ideal; restarts clear fail registers.
      f0 = 1'b1;
      start0 = 1'b1;
      @(negedge clk);
      e = cyc;
      q0.push_back(mk(1'b0, 8'h80, 3'd3, 8'd0, e + 12));
      q0.push_back(mk(1'b1, 8'h00, 3'd0, 8'd0, e + 37));
      q0.push_back(mk(1'b1, 8'h00, 3'd0, 8'd0, e + 62));
      wait_until(e + 12);
      f0 = 1'b0;
      wait_until(e + 13);
      chk("held done_pulse", {31'd0, done0}, 0);
      chk("held restart_busy", {31'd0, busy0}, 1);
      chk("held mask_cleared", {24'd0, fm0}, 0);
      wait_until(e + 38);
      chk("held done_pulse2", {31'd0, done0}, 0);
      wait_until(e + 62);
      start0 = 1'b0;
      wait_until(e + 64);
      chk("held final_done", {31'd0, done0}, 1);
      chk("held final_busy", {31'd0, busy0}, 0);

      // SETTLE=1, start toggled while busy: no effect, done at E+16.
      start2 = 1'b1;
      @(negedge clk);
      e = cyc;
      start2 = 1'b0;
      q2.push_back(mk(1'b1, 8'h00, 3'd0, 8'd0, e + 16));
      for (t = 0; t < 16; t++) begin
         if (t > 0) @(negedge clk);
         start2 = (t >= 1 && t <= 10) ? t[0] : 1'b0;
         chk("toggle abc", {29'd0, c2, b2, a2}, t / 2);
      end
      start2 = 1'b0;
      wait_until(e + 18);

      // Every expected completion must have been observed.
      t = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("pending_u0", q0.size(), 0);
      chk("pending_u1", q1.size(), 0);
      chk("pending_u2", q2.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: cycle %0d, expected completion before limit", cyc);
      $fatal(1);
   end

endmodule
